// File: rtl/request_controller.sv
// Master-side request capture stage of a crossbar port handler.
// Turns each 4-phase master request into exactly one entry of a small
// show-ahead FIFO that feeds the slave-side arbiter over valid/ready.
module request_controller #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       req,
    input  logic                       cmd,
    input  logic [AWIDTH-1:0]          addr,
    input  logic [DWIDTH-1:0]          wdata,
    output logic                       fifo_full,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_cmd,
    output logic [AWIDTH-1:0]          out_addr,
    output logic [DWIDTH-1:0]          out_wdata,
    output logic                       out_sel,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        WAIT_REQ_HIGH = 2'd1,
        WAIT_SPACE    = 2'd2,
        WAIT_REQ_LOW  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              push_s;
    logic              pop_s;
    logic              space_s;
    logic              empty_s;

    // Storage is deliberately left out of reset; only pointers/count qualify it.
    logic              mem_cmd_r   [DEPTH];
    logic [AWIDTH-1:0] mem_addr_r  [DEPTH];
    logic [DWIDTH-1:0] mem_wdata_r [DEPTH];

    // Occupancy decodes: flags depend only on the count register.
    assign empty_s   = (count_r == CW'(0));
    assign fifo_full = (count_r == CW'(DEPTH));
    assign out_valid = !empty_s;
    assign count     = count_r;

    // A pop frees a slot in the same edge, so a full FIFO still has space then.
    assign pop_s   = out_valid && out_ready;
    assign space_s = !fifo_full || pop_s;

    // Request-capture FSM: exactly one push per req high period.
    always_comb begin
        state_next_s = state_r;
        push_s       = 1'b0;
        case (state_r)
            IDLE: begin
                state_next_s = WAIT_REQ_HIGH;
            end
            WAIT_REQ_HIGH: begin
                if (req) begin
                    if (space_s) begin
                        push_s       = 1'b1;
                        state_next_s = WAIT_REQ_LOW;
                    end else begin
                        state_next_s = WAIT_SPACE;
                    end
                end else begin
                    state_next_s = WAIT_REQ_HIGH;
                end
            end
            WAIT_SPACE: begin
                if (!req) begin
                    // master gave up before a slot opened: nothing is stored
                    state_next_s = WAIT_REQ_HIGH;
                end else if (space_s) begin
                    push_s       = 1'b1;
                    state_next_s = WAIT_REQ_LOW;
                end else begin
                    state_next_s = WAIT_SPACE;
                end
            end
            WAIT_REQ_LOW: begin
                if (!req) begin
                    state_next_s = WAIT_REQ_HIGH;
                end else begin
                    state_next_s = WAIT_REQ_LOW;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage write; request fields are sampled at the push edge.
    always_ff @(posedge aclk) begin
        if (push_s) begin
            mem_cmd_r[wr_ptr_r]   <= cmd;
            mem_addr_r[wr_ptr_r]  <= addr;
            mem_wdata_r[wr_ptr_r] <= wdata;
        end
    end

    // Show-ahead head fields, forced to zero while the FIFO is empty.
    always_comb begin
        out_cmd   = 1'b0;
        out_addr  = AWIDTH'(0);
        out_wdata = DWIDTH'(0);
        if (out_valid) begin
            out_cmd   = mem_cmd_r[rd_ptr_r];
            out_addr  = mem_addr_r[rd_ptr_r];
            out_wdata = mem_wdata_r[rd_ptr_r];
        end else begin
            out_cmd   = 1'b0;
            out_addr  = AWIDTH'(0);
            out_wdata = DWIDTH'(0);
        end
    end

    assign out_sel = out_addr[AWIDTH-1];

endmodule

// File: tb/tb_request_controller.sv
// Directed self-checking bench for request_controller (DEPTH = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_request_controller;

    logic        aclk;
    logic        areset;
    logic        req;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        fifo_full;
    logic        out_valid;
    logic        out_ready;
    logic        out_cmd;
    logic [31:0] out_addr;
    logic [31:0] out_wdata;
    logic        out_sel;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    request_controller #(.AWIDTH(32), .DWIDTH(32), .DEPTH(4)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .req       (req),
        .cmd       (cmd),
        .addr      (addr),
        .wdata     (wdata),
        .fifo_full (fifo_full),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cmd   (out_cmd),
        .out_addr  (out_addr),
        .out_wdata (out_wdata),
        .out_sel   (out_sel),
        .count     (count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Stimulus helpers (no checking inside).
    task automatic tick();
        @(negedge aclk);
    endtask

    task automatic pulse_ready();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic send_req(input logic c, input logic [31:0] a, input logic [31:0] d,
                            input int hi, input int lo);
        req = 1'b1; cmd = c; addr = a; wdata = d;
        repeat (hi) tick();
        req = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic test_reset();
        areset = 1'b1; req = 1'b0; cmd = 1'b0; addr = 32'h0; wdata = 32'h0; out_ready = 1'b0;
        tick(); tick();
        n_checks++;
        if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++;
        if (out_valid !== 1'b0 || fifo_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got valid=%b full=%b expected 0 0", out_valid, fifo_full);
        end
        n_checks++;
        if (out_addr !== 32'h0 || out_wdata !== 32'h0 || out_cmd !== 1'b0 || out_sel !== 1'b0) begin
            n_fail++; $display("FAIL reset_head: got addr=%h wdata=%h expected zeros", out_addr, out_wdata);
        end
        areset = 1'b0;
    endtask

    task automatic test_single_write();
        req = 1'b1; cmd = 1'b1; addr = 32'h8000_0010; wdata = 32'hDEAD_BEEF;
        tick();
        n_checks++;
        if (count !== 3'd0) begin n_fail++; $display("FAIL single_first_edge: got count %0d expected 0", count); end
        tick();
        n_checks++;
        if (count !== 3'd1 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL single_push: got count %0d valid %b expected 1 1", count, out_valid);
        end
        n_checks++;
        if (out_addr !== 32'h8000_0010 || out_wdata !== 32'hDEAD_BEEF || out_cmd !== 1'b1 || out_sel !== 1'b1) begin
            n_fail++; $display("FAIL single_head: got cmd=%b addr=%h wdata=%h sel=%b expected 1 80000010 deadbeef 1",
                               out_cmd, out_addr, out_wdata, out_sel);
        end
        repeat (9) tick();
        n_checks++;
        if (count !== 3'd1) begin n_fail++; $display("FAIL single_hold: got count %0d expected 1", count); end
        req = 1'b0;
        pulse_ready();
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_pop: got count %0d valid %b expected 0 0", count, out_valid);
        end
    endtask

    task automatic test_fill_and_abandon();
        logic [31:0] exp_addr [4];
        exp_addr = '{32'h0000_0008, 32'h0000_000C, 32'h0000_0010, 32'h0000_0020};
        for (int i = 0; i < 4; i++) send_req(1'b0, 32'(i * 4), 32'h1000 + 32'(i), 3, 2);
        n_checks++;
        if (count !== 3'd4 || fifo_full !== 1'b1) begin
            n_fail++; $display("FAIL fill_full: got count %0d full %b expected 4 1", count, fifo_full);
        end
        n_checks++;
        if (out_addr !== 32'h0 || out_cmd !== 1'b0 || out_wdata !== 32'h1000) begin
            n_fail++; $display("FAIL fill_head: got addr=%h wdata=%h expected 0 1000", out_addr, out_wdata);
        end
        // fifth request waits for space
        req = 1'b1; cmd = 1'b0; addr = 32'h0000_0010; wdata = 32'h1004;
        tick(); tick();
        n_checks++;
        if (count !== 3'd4) begin n_fail++; $display("FAIL wait_space: got count %0d expected 4", count); end
        pulse_ready();
        n_checks++;
        if (count !== 3'd4 || out_addr !== 32'h0000_0004) begin
            n_fail++; $display("FAIL full_push_pop: got count %0d head %h expected 4 00000004", count, out_addr);
        end
        req = 1'b0; tick(); tick();
        // abandoned request while full
        req = 1'b1; addr = 32'h0000_0014; wdata = 32'hBAD0;
        tick(); tick();
        req = 1'b0;
        tick(); tick();
        n_checks++;
        if (count !== 3'd4 || out_addr !== 32'h0000_0004) begin
            n_fail++; $display("FAIL abandon: got count %0d head %h expected 4 00000004", count, out_addr);
        end
        pulse_ready();
        n_checks++;
        if (count !== 3'd3 || fifo_full !== 1'b0) begin
            n_fail++; $display("FAIL abandon_pop: got count %0d full %b expected 3 0", count, fifo_full);
        end
        send_req(1'b1, 32'h0000_0020, 32'h2020, 2, 2);
        n_checks++;
        if (count !== 3'd4) begin n_fail++; $display("FAIL after_abandon: got count %0d expected 4", count); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_addr !== exp_addr[i]) begin
                n_fail++; $display("FAIL drain_order_%0d: got %h expected %h", i, out_addr, exp_addr[i]);
            end
            pulse_ready();
        end
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_addr !== 32'h0) begin
            n_fail++; $display("FAIL drain_empty: got count %0d valid %b addr %h expected 0 0 0", count, out_valid, out_addr);
        end
    endtask

    task automatic test_back_to_back();
        send_req(1'b0, 32'h0000_0100, 32'h100, 2, 2);
        n_checks++;
        if (count !== 3'd1) begin n_fail++; $display("FAIL b2b_setup: got count %0d expected 1", count); end
        req = 1'b1; cmd = 1'b1; addr = 32'h0000_0104; wdata = 32'h5555_AAAA; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (count !== 3'd1 || out_addr !== 32'h0000_0104 || out_wdata !== 32'h5555_AAAA || out_cmd !== 1'b1) begin
            n_fail++; $display("FAIL b2b_push_pop: got count %0d addr %h wdata %h expected 1 00000104 5555aaaa",
                               count, out_addr, out_wdata);
        end
        req = 1'b0; tick(); tick();
        pulse_ready();
        n_checks++;
        if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_drain: got count %0d expected 0", count); end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req = 1'b1; cmd = 1'b0; addr = 32'h0000_0200 + 32'(i * 4); wdata = 32'(i);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || count !== 3'd1 || out_addr !== 32'h0000_0200 + 32'(i * 4) || out_wdata !== 32'(i)) begin
                n_fail++; $display("FAIL wrap_%0d: got valid %b count %0d addr %h expected 1 1 %h",
                                   i, out_valid, count, out_addr, 32'h0000_0200 + 32'(i * 4));
            end
            req = 1'b0;
            tick();
            n_checks++;
            if (count !== 3'd0) begin n_fail++; $display("FAIL wrap_pop_%0d: got count %0d expected 0", i, count); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) send_req(1'b1, 32'h0000_0280 + 32'(i), 32'h0, 1, 1);
        n_checks++;
        if (count !== 3'd3) begin n_fail++; $display("FAIL areset_setup: got count %0d expected 3", count); end
        req = 1'b1; cmd = 1'b1; addr = 32'h8000_0300; wdata = 32'hCAFE_F00D;
        @(posedge aclk);
        #2 areset = 1'b1;
        #1;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || fifo_full !== 1'b0) begin
            n_fail++; $display("FAIL areset_async: got count %0d valid %b full %b expected 0 0 0", count, out_valid, fifo_full);
        end
        #1 areset = 1'b0;
        tick();
        tick();
        n_checks++;
        if (count !== 3'd0) begin n_fail++; $display("FAIL areset_first_edge: got count %0d expected 0", count); end
        tick();
        n_checks++;
        if (count !== 3'd1 || out_addr !== 32'h8000_0300 || out_sel !== 1'b1) begin
            n_fail++; $display("FAIL areset_capture: got count %0d addr %h sel %b expected 1 80000300 1", count, out_addr, out_sel);
        end
        req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_and_abandon();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/request_controller.md
Name: request_controller

Overview:
- Master-side request capture stage of a crossbar port handler. It sits directly upstream of the port's answer controller.
- Detects each new 4-phase master request (req/cmd/addr/wdata) and enqueues exactly one entry per request into a small show-ahead FIFO.
- The FIFO feeds the slave-side arbiter over a valid/ready handshake.
- Exports fifo_full so the answer controller can decide whether to acknowledge a read.

Parameters:
AWIDTH, 32, address width; addr[AWIDTH-1] selects the slave.
DWIDTH, 32, write data width.
DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
aclk  in  1  clock; all logic on the rising edge
areset  in  1  asynchronous, active-high reset
req  in  1  master request; held high until the master sees ack, then dropped
cmd  in  1  0 = read, 1 = write
addr  in  AWIDTH  request address
wdata  in  DWIDTH  write data; ignored for reads but still stored
fifo_full  out  1  high when count == DEPTH
out_valid  out  1  FIFO head valid (count != 0)
out_ready  in  1  slave side accepts the head
out_cmd  out  1  head command
out_addr  out  AWIDTH  head address
out_wdata  out  DWIDTH  head write data
out_sel  out  1  out_addr[AWIDTH-1]
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (areset high, asynchronous): state = IDLE, pointers = 0, count = 0.
  - While in reset and after release: fifo_full = 0, out_valid = 0.
  - out_cmd, out_addr, out_wdata and out_sel are forced to 0 whenever count == 0.
  - Storage contents are not reset.
- FSM states: IDLE, WAIT_REQ_HIGH, WAIT_SPACE, WAIT_REQ_LOW.
  - IDLE -> WAIT_REQ_HIGH unconditionally after 1 cycle. A req already high at reset release is therefore captured no earlier than the 2nd edge after release.
  - WAIT_REQ_HIGH, req = 1 and no space: go to WAIT_SPACE. No space means count == DEPTH and there is no pop in the same cycle.
  - WAIT_REQ_HIGH, req = 1 and space: push {cmd, addr, wdata} at this edge, go to WAIT_REQ_LOW.
  - WAIT_SPACE: push on the first edge where space exists (a pop in the same cycle counts as space), then go to WAIT_REQ_LOW. cmd/addr/wdata are sampled at the push edge; the master holds them stable while req is high.
  - WAIT_SPACE, req drops before space: return to WAIT_REQ_HIGH with no push (request abandoned).
  - WAIT_REQ_LOW -> WAIT_REQ_HIGH when req = 0.
  - Exactly one push per req high period, regardless of how long req stays high.
- Latency: request sampled at edge k with an empty FIFO gives out_valid = 1 and head fields valid immediately after edge k.
- Pop: occurs at an edge where out_valid && out_ready. out_ready while empty is ignored.
- Push and pop in the same edge: count unchanged, both pointers advance. This is allowed even at count == DEPTH (the pop frees the slot).
- Pointers: $clog2(DEPTH) bits, natural wrap DEPTH-1 -> 0.
- count range: 0..DEPTH; it never over- or underflows.
- Derived outputs:
  - fifo_full and out_valid are pure decodes of the count register: no combinational path from req/out_ready.
  - Head fields are read from storage[rd_ptr].
- Ordering is strictly FIFO.
- Reset mid-operation: all state is discarded immediately, including entries not yet popped and a pending WAIT_SPACE request.

Test Plan:
- Single write: after reset, req = 1, cmd = 1, addr = 0x8000_0010, wdata = 0xDEAD_BEEF, out_ready = 0 -> one cycle after sampling, out_valid = 1, out_sel = 1, out_addr = 0x8000_0010, out_wdata = 0xDEAD_BEEF, count = 1. req held 10 cycles -> count stays 1.
- Fill to full: 4 reads (cmd = 0, addr = 0x0000_0000..0x0000_000C), each req high 3 cycles then low 2, out_ready = 0 -> count = 4, fifo_full = 1. A 5th req enters WAIT_SPACE.
  - out_ready pulsed 1 cycle -> 5th entry pushed on that same edge, count stays 4.
  - Head shows addr 0x0000_0004, then 0x0000_0008, 0x0000_000C, 5th entry in order.
- Abandoned request: FIFO full, req high 2 cycles then low with no pop -> count stays 4, no entry added. Next req after a pop is accepted normally.
- Simultaneous push/pop: count = 1, out_ready = 1 on the same edge as a new request sample -> count stays 1, head becomes the new request.
- Wrap-around: 12 sequential single requests with out_ready = 1 -> each appears on out_* one cycle after sampling, addresses in order, count never exceeds 1, pointers wrap 3 times.
- Async reset mid-operation: count = 3, areset pulsed for half a cycle -> out_valid = 0, fifo_full = 0, count = 0 without waiting for a clock edge. A req held high through release is captured on the 2nd edge after release.
